imm_ext_pipe: RTL and testbench

//   Parametrised, pipelined immediate-extension stage for the decode->execute path.

---
 rtl/imm_ext_pipe.sv | 126 ++++++++++++
 tb/tb_imm_ext_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//   Pipelined immediate-extension stage on the decode->execute path.
//   The stage widens an IN_W-bit immediate to OUT_W bits in one of four modes:
//   zero-extend, sign-extend, upper, or branch offset (sign-extend, then << 2).
//   Extension is combinational on the input and the result is registered, so
//   an accepted beat appears on out_ext one cycle later.
//   Storage is a main register that drives out_* and a one-entry skid
//   register. The skid register absorbs the one beat that arrives while execute
//   stalls, so no immediate is ever dropped. in_ready depends only on
//   registered state, which keeps out_ready off the input-side timing path.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      synchronous discard of all held beats (branch redirect)
//   in_valid   input beat valid
//   in_ready   stage can accept a beat this cycle
//   in_imm     raw immediate, IN_W bits
//   in_mode    00 zero, 01 sign, 10 upper, 11 branch (sign-extend, then << 2)
//   in_tag     sideband tag, passed through unchanged
//   out_valid  output beat valid
//   out_ready  consumer accepts the beat
//   out_ext    extended immediate, OUT_W bits
//   out_tag    tag of the beat on out_ext
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_ext,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] ext_zero;
    logic [OUT_W-1:0] ext_sign;
    logic [OUT_W-1:0] ext_upper;
    logic [OUT_W-1:0] ext_branch;
    logic [OUT_W-1:0] ext_nxt;

    logic             main_valid;
    logic [OUT_W-1:0] main_ext;
    logic [TAG_W-1:0] main_tag;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_ext;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             deliver;
    logic             main_free;

    assign ext_zero   = {{PAD_W{1'b0}}, in_imm};
    assign ext_sign   = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    assign ext_upper  = {in_imm, {PAD_W{1'b0}}};
    // With OUT_W >= IN_W+2, the two bits shifted out of the top are sign
    // copies, so the upper bits of the result stay sign-filled.
    assign ext_branch = ext_sign << 2;

    always_comb begin
        ext_nxt = ext_zero;
        case (in_mode)
            2'b00:   ext_nxt = ext_zero;
            2'b01:   ext_nxt = ext_sign;
            2'b10:   ext_nxt = ext_upper;
            default: ext_nxt = ext_branch;
        endcase
    end

    assign in_ready  = !skid_valid && !rst;
    assign accept    = in_valid && in_ready;
    assign deliver   = main_valid && out_ready;
    assign main_free = !main_valid || deliver;

    assign out_valid = main_valid;
    assign out_ext   = main_ext;
    assign out_tag   = main_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ext   <= '0;
            main_tag   <= '0;
            skid_valid <= 1'b0;
            skid_ext   <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            // Only the valid bits clear. A beat accepted in this cycle is
            // dropped because nothing is loaded.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // When the skid register is full, in_ready is low, so the skid
            // beat and a new beat never compete for the main register.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_ext   <= skid_ext;
                main_tag   <= skid_tag;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_ext   <= ext_nxt;
                main_tag   <= in_tag;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ext   <= ext_nxt;
            skid_tag   <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_ext;
    logic [TAG_W-1:0] out_tag;

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ext   (out_ext),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [OUT_W-1:0] ext;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t            q[$];      // beats the stage must currently hold, oldest first
    logic [TAG_W-1:0] dlog[$];   // tags observed leaving the DUT
    bit               m_acc;
    bit               m_dlv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension rules expressed as signed/unsigned integer arithmetic.
    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint u;
        longint s;
        longint r;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = u * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    // Occupancy model: a FIFO of at most two beats.
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_dlv = (q.size() > 0) && out_ready;
            if (m_dlv) void'(q.pop_front());
            if (m_acc) q.push_back('{ext: model_ext(in_imm, in_mode), tag: in_tag});
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'(!rst && (q.size() < 2)));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_ext", out_ext, q[0].ext);
                chk("out_tag", 32'(out_tag), 32'(q[0].tag));
            end
            if (out_valid && out_ready) dlog.push_back(out_tag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] v_imm [4] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF};
    logic [31:0] v_exp [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFFFFFC};

    initial begin
        int next_tag;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0, 2'd0, 5'd0);

        // Reset held for three cycles
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ext", out_ext, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Mode vectors, one cycle latency, tags 1..4
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v_imm[i], 2'(i), 5'(i + 1));
            step();
            chk($sformatf("mode%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("mode%0d_ext", i), out_ext, v_exp[i]);
            chk($sformatf("mode%0d_tag", i), 32'(out_tag), 32'(i + 1));
        end
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        repeat (2) step();

        // Backpressure: four beats, out_ready low for three cycles after the first lands
        dlog.delete();
        next_tag = 1;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            if (next_tag <= 4) drive(1'b1, 16'(16'h0100 * next_tag), 2'(next_tag), 5'(next_tag));
            else drive(1'b0, 16'h0, 2'd0, 5'd0);
            if (in_valid && in_ready) next_tag++;
            step();
            if (c == 1) chk("bp_skid_in_ready", 32'(in_ready), 32'd0);
            if (c == 1) chk("bp_main_tag", 32'(out_tag), 32'd1);
        end
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        out_ready = 1'b1;
        step();
        chk("bp_n_delivered", 32'(dlog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < dlog.size()) chk($sformatf("bp_order%0d", i), 32'(dlog[i]), 32'(i + 1));

        // Flush with both entries full and a beat offered in the flush cycle
        dlog.delete();
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 2'd0, 5'd10);
        step();
        drive(1'b1, 16'h00BB, 2'd1, 5'd11);
        step();
        chk("fl_full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 16'h00CC, 2'd2, 5'd12);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("fl_nothing_out", 32'(dlog.size()), 32'd0);

        // Continuous streaming, 16 back-to-back beats
        dlog.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'(16'h1234 + i * 16'h0F0F), 2'(i % 4), 5'(i));
            chk($sformatf("str_in_ready%0d", i), 32'(in_ready), 32'd1);
            step();
        end
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        step();
        chk("str_n_delivered", 32'(dlog.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < dlog.size()) chk($sformatf("str_order%0d", i), 32'(dlog[i]), 32'(i));

        // Reset while the skid register is full
        out_ready = 1'b0;
        drive(1'b1, 16'h0055, 2'd0, 5'd20);
        step();
        drive(1'b1, 16'h0066, 2'd0, 5'd21);
        step();
        chk("rs_full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        #1;
        chk("rs_out_ext", out_ext, 32'd0);
        chk("rs_out_tag", 32'(out_tag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rs_idle%0d", i), 32'(out_valid), 32'd0);
        end
        drive(1'b1, 16'h0001, 2'd3, 5'd7);
        step();
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        chk("rs_new_ext", out_ext, 32'h00000004);
        chk("rs_new_tag", 32'(out_tag), 32'd7);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
